// File: rtl/params_pkg.sv
// Shared sizing defaults for the fetch path, plus a helper for occupancy-counter widths.
package params_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int MEM_SIZE   = 256;
    localparam int FQ_DEPTH   = 4;
    localparam int RESET_PC   = 0;

    // Bits needed to hold a count from 0 to depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; read data is the current head, valid whenever empty_o is low.
module fetch_fifo
    import params_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [WIDTH-1:0]              data_i,
    output logic [WIDTH-1:0]              data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign data_o  = mem[rd_ptr];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr] <= data_i;
    end

    a_no_overflow:  assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o && !pop_i));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/fetch_unit.sv
// Sequential fetch stage: owns the fetch PC, issues credited memory requests, buffers
// responses for decode and discards responses that were in flight across a redirect.
module fetch_unit
    import params_pkg::*;
#(
    parameter int ADDR_WIDTH  = params_pkg::ADDR_WIDTH,
    parameter int INSTR_WIDTH = 32,
    parameter int MEM_SIZE    = params_pkg::MEM_SIZE,
    parameter int FQ_DEPTH    = params_pkg::FQ_DEPTH,
    parameter int RESET_PC    = params_pkg::RESET_PC
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alu_branch_taken_i,
    input  logic [ADDR_WIDTH-1:0]  pc_branch_offset_i,
    input  logic                   is_jump_i,
    input  logic [ADDR_WIDTH-1:0]  jump_address_i,
    output logic                   imem_req_valid_o,
    input  logic                   imem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr_o,
    input  logic                   imem_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_o
);

    localparam int CW = cnt_width(FQ_DEPTH);
    localparam int QW = ADDR_WIDTH + INSTR_WIDTH;
    localparam logic [CW:0]           CREDIT_LIM = (CW + 1)'(FQ_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_LAST    = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_RESET   = ADDR_WIDTH'(RESET_PC);

    logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_next, target;
    logic [CW-1:0]         live_cnt, live_cnt_next;
    logic [CW-1:0]         drop_cnt, drop_cnt_next;
    logic [CW-1:0]         fq_count, pcq_count;
    logic                  redirect, req_fire, rsp_live, pop;
    logic                  fq_full, fq_empty, pcq_full, pcq_empty;
    logic [QW-1:0]         fq_rdata;
    logic [ADDR_WIDTH-1:0] pcq_head;

    assign redirect = is_jump_i | alu_branch_taken_i;
    assign target   = ADDR_WIDTH'(32'(is_jump_i ? jump_address_i : pc_branch_offset_i) % 32'(MEM_SIZE));

    // Credits come from registered counts only, so a same-cycle pop or response never frees a slot early.
    assign imem_req_valid_o = !redirect
                           && (({1'b0, fq_count} + {1'b0, live_cnt}) < CREDIT_LIM)
                           && (({1'b0, live_cnt} + {1'b0, drop_cnt}) < CREDIT_LIM);
    assign imem_req_addr_o  = fetch_pc;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign rsp_live         = imem_rsp_valid_i && (drop_cnt == '0) && !redirect;

    assign instr_valid_o = !fq_empty && !redirect;
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_o       = fq_empty ? '0 : fq_rdata[INSTR_WIDTH-1:0];
    assign instr_pc_o    = fq_empty ? '0 : fq_rdata[QW-1 -: ADDR_WIDTH];

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        fetch_pc_next = fetch_pc;
        live_cnt_next = live_cnt;
        drop_cnt_next = drop_cnt;
        if (redirect) begin
            fetch_pc_next = target;
            live_cnt_next = '0;
            // An arriving response is the oldest in flight, so it retires one of the accumulated drops.
            drop_cnt_next = drop_cnt + live_cnt - CW'(imem_rsp_valid_i);
        end else begin
            if (req_fire) begin
                fetch_pc_next = (fetch_pc == PC_LAST) ? '0 : fetch_pc + ADDR_WIDTH'(1);
            end
            live_cnt_next = live_cnt + CW'(req_fire) - CW'(rsp_live);
            if (imem_rsp_valid_i && (drop_cnt != '0)) begin
                drop_cnt_next = drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= PC_RESET;
            live_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            fetch_pc <= fetch_pc_next;
            live_cnt <= live_cnt_next;
            drop_cnt <= drop_cnt_next;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (FQ_DEPTH)
    ) u_pc_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect),
        .push_i  (req_fire),
        .pop_i   (rsp_live),
        .data_i  (fetch_pc),
        .data_o  (pcq_head),
        .full_o  (pcq_full),
        .empty_o (pcq_empty),
        .count_o (pcq_count)
    );

    fetch_fifo #(
        .WIDTH (QW),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect),
        .push_i  (rsp_live),
        .pop_i   (pop),
        .data_i  ({pcq_head, imem_rsp_data_i}),
        .data_o  (fq_rdata),
        .full_o  (fq_full),
        .empty_o (fq_empty),
        .count_o (fq_count)
    );

    a_no_orphan_rsp:   assert property (@(posedge clk_i) disable iff (rst_i)
                           !(imem_rsp_valid_i && (live_cnt == '0) && (drop_cnt == '0)));
    a_pcq_has_head:    assert property (@(posedge clk_i) disable iff (rst_i) !(rsp_live && pcq_empty));
    a_pcq_tracks_live: assert property (@(posedge clk_i) disable iff (rst_i) pcq_count == live_cnt);
    a_pcq_credit:      assert property (@(posedge clk_i) disable iff (rst_i) !(req_fire && pcq_full));
    a_fq_credit:       assert property (@(posedge clk_i) disable iff (rst_i) !(rsp_live && fq_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 256-word instance with variable memory latency and
// an 8-word instance starting at PC 6 to exercise address wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        branch_taken = 1'b0;
    logic [7:0]  branch_off   = '0;
    logic        is_jump      = 1'b0;
    logic [7:0]  jump_addr    = '0;
    logic        req_valid;
    logic        req_ready    = 1'b1;
    logic [7:0]  req_addr;
    logic        rsp_valid    = 1'b0;
    logic [31:0] rsp_data     = '0;
    logic        instr_valid;
    logic        instr_ready  = 1'b1;
    logic [31:0] instr;
    logic [7:0]  instr_pc;

    logic        b_zero       = 1'b0;
    logic [7:0]  b_zero_addr  = '0;
    logic        b_one        = 1'b1;
    logic        b_req_valid;
    logic [7:0]  b_req_addr;
    logic        b_rsp_valid  = 1'b0;
    logic [31:0] b_rsp_data   = '0;
    logic        b_instr_valid;
    logic [31:0] b_instr;
    logic [7:0]  b_instr_pc;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;

    fetch_unit #(
        .ADDR_WIDTH (8), .INSTR_WIDTH (32), .MEM_SIZE (256), .FQ_DEPTH (4), .RESET_PC (0)
    ) dut (
        .clk_i (clk), .rst_i (rst),
        .alu_branch_taken_i (branch_taken), .pc_branch_offset_i (branch_off),
        .is_jump_i (is_jump), .jump_address_i (jump_addr),
        .imem_req_valid_o (req_valid), .imem_req_ready_i (req_ready), .imem_req_addr_o (req_addr),
        .imem_rsp_valid_i (rsp_valid), .imem_rsp_data_i (rsp_data),
        .instr_valid_o (instr_valid), .instr_ready_i (instr_ready),
        .instr_o (instr), .instr_pc_o (instr_pc)
    );

    fetch_unit #(
        .ADDR_WIDTH (8), .INSTR_WIDTH (32), .MEM_SIZE (8), .FQ_DEPTH (4), .RESET_PC (6)
    ) dut_wrap (
        .clk_i (clk), .rst_i (rst),
        .alu_branch_taken_i (b_zero), .pc_branch_offset_i (b_zero_addr),
        .is_jump_i (b_zero), .jump_address_i (b_zero_addr),
        .imem_req_valid_o (b_req_valid), .imem_req_ready_i (b_one), .imem_req_addr_o (b_req_addr),
        .imem_rsp_valid_i (b_rsp_valid), .imem_rsp_data_i (b_rsp_data),
        .instr_valid_o (b_instr_valid), .instr_ready_i (b_one),
        .instr_o (b_instr), .instr_pc_o (b_instr_pc)
    );

    initial forever #5 clk = ~clk;

    // Memory models: in-order, reset with the block; data word encodes the address.
    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  addr;
    } mreq_t;

    mreq_t mq[$];

    initial begin
        logic [31:0] cyc;
        logic        fire_a, fire_b, rst_s;
        logic [7:0]  addr_a, addr_b;
        mreq_t       head;
        cyc = '0;
        forever begin
            @(posedge clk);
            fire_a = req_valid && req_ready;
            addr_a = req_addr;
            fire_b = b_req_valid;
            addr_b = b_req_addr;
            rst_s  = rst;
            cyc    = cyc + 1;
            #1;
            if (rst_s) begin
                mq.delete();
                rsp_valid   = 1'b0;
                rsp_data    = '0;
                b_rsp_valid = 1'b0;
                b_rsp_data  = '0;
            end else begin
                if (fire_a === 1'b1) mq.push_back('{due: cyc + 32'(mem_lat) - 1, addr: addr_a});
                if (mq.size() > 0 && mq[0].due == cyc) begin
                    head      = mq.pop_front();
                    rsp_valid = 1'b1;
                    rsp_data  = 32'hC000_0000 | {24'h0, head.addr};
                end else begin
                    rsp_valid = 1'b0;
                    rsp_data  = '0;
                end
                b_rsp_valid = (fire_b === 1'b1);
                b_rsp_data  = 32'hB000_0000 | {24'h0, addr_b};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench in the first cycle after reset.
    task automatic do_reset();
        rst          = 1'b1;
        is_jump      = 1'b0;
        branch_taken = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        mem_lat = 1; req_ready = 1'b1; instr_ready = 1'b1;
        do_reset();
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid: got %b want 1", req_valid); end
        checks++; if (req_addr !== 8'h00) begin errors++; $display("FAIL reset_req_addr: got %h want 00", req_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== 8'h00) begin errors++; $display("FAIL reset_instr_pc: got %h want 00", instr_pc); end
    endtask

    task automatic test_sequential();
        mem_lat = 1; req_ready = 1'b1; instr_ready = 1'b1;
        do_reset();
        step();
        checks++; if (req_addr !== 8'h01) begin errors++; $display("FAIL seq_c1_addr: got %h want 01", req_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_c1_valid: got %b want 0", instr_valid); end
        step();
        for (int k = 0; k < 6; k++) begin
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b want 1", k, instr_valid); end
            checks++; if (instr_pc !== 8'(k)) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", k, instr_pc, 8'(k)); end
            checks++; if (instr !== (32'hC000_0000 + 32'(k))) begin errors++; $display("FAIL seq_instr[%0d]: got %h want %h", k, instr, 32'hC000_0000 + 32'(k)); end
            checks++; if (req_addr !== 8'(k + 2)) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", k, req_addr, 8'(k + 2)); end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [4];
        seq = '{8'd6, 8'd7, 8'd0, 8'd1};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                checks++; if (b_req_addr !== seq[k]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, b_req_addr, seq[k]); end
            end
            if (k >= 2) begin
                checks++; if (b_instr_pc !== seq[k-2]) begin errors++; $display("FAIL wrap_pc[%0d]: got %h want %h", k, b_instr_pc, seq[k-2]); end
                checks++; if (b_instr !== (32'hB000_0000 | {24'h0, seq[k-2]})) begin errors++; $display("FAIL wrap_instr[%0d]: got %h", k, b_instr); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int fires;
        mem_lat = 1; req_ready = 1'b1; instr_ready = 1'b0;
        do_reset();
        fires = 0;
        for (int k = 0; k < 8; k++) begin
            if (req_valid && req_ready) fires++;
            step();
        end
        checks++; if (fires != 4) begin errors++; $display("FAIL bp_fires: got %0d want 4", fires); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", req_valid); end
        instr_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'(k)) begin
                errors++; $display("FAIL bp_release[%0d]: got valid %b pc %h want 1 %h", k, instr_valid, instr_pc, 8'(k));
            end
            checks++; if (instr !== (32'hC000_0000 + 32'(k))) begin errors++; $display("FAIL bp_instr[%0d]: got %h", k, instr); end
            step();
        end
    endtask

    // Waits (bounded) for the first instruction and compares its PC and word.
    task automatic expect_first(input string name, input logic [7:0] pc);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (instr_valid === 1'b1) found = 1'b1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL %s_timeout: got no instr_valid want pc %h", name, pc);
        end else if (instr_pc !== pc || instr !== (32'hC000_0000 | {24'h0, pc})) begin
            errors++; $display("FAIL %s_first: got pc %h instr %h want pc %h", name, instr_pc, instr, pc);
        end
    endtask

    task automatic test_redirect_drop();
        mem_lat = 3; req_ready = 1'b1; instr_ready = 1'b1;
        do_reset();
        step();
        step();
        is_jump = 1'b1; jump_addr = 8'h20;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rd_req_valid: got %b want 0", req_valid); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_instr_valid: got %b want 0", instr_valid); end
        step();
        is_jump = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b1 || req_addr !== 8'h20) begin
            errors++; $display("FAIL rd_next_req: got valid %b addr %h want 1 20", req_valid, req_addr);
        end
        expect_first("rd", 8'h20);
    endtask

    task automatic test_jump_priority();
        mem_lat = 1; req_ready = 1'b1; instr_ready = 1'b1;
        do_reset();
        is_jump = 1'b1; jump_addr = 8'h10;
        branch_taken = 1'b1; branch_off = 8'h30;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL jp_req_valid: got %b want 0", req_valid); end
        step();
        is_jump = 1'b0; branch_taken = 1'b0;
        #1;
        checks++; if (req_addr !== 8'h10) begin errors++; $display("FAIL jp_addr: got %h want 10", req_addr); end
        branch_taken = 1'b1; branch_off = 8'h30;
        step();
        branch_taken = 1'b0;
        #1;
        checks++; if (req_addr !== 8'h30) begin errors++; $display("FAIL br_addr: got %h want 30", req_addr); end
    endtask

    task automatic test_back_to_back();
        mem_lat = 3; req_ready = 1'b1; instr_ready = 1'b1;
        do_reset();
        step();
        step();
        is_jump = 1'b1; jump_addr = 8'h40;
        step();
        is_jump = 1'b0; branch_taken = 1'b1; branch_off = 8'h50;
        step();
        branch_taken = 1'b0;
        #1;
        checks++; if (req_addr !== 8'h50) begin errors++; $display("FAIL b2b_addr: got %h want 50", req_addr); end
        expect_first("b2b", 8'h50);
    endtask

    task automatic test_reset_mid();
        mem_lat = 3; req_ready = 1'b1; instr_ready = 1'b0;
        do_reset();
        repeat (10) step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rm_prefill: got %b want 1", instr_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rm_instr_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0 || instr_pc !== 8'h00) begin errors++; $display("FAIL rm_head: got %h/%h want 0/0", instr, instr_pc); end
        checks++; if (req_valid !== 1'b1 || req_addr !== 8'h00) begin
            errors++; $display("FAIL rm_req: got valid %b addr %h want 1 00", req_valid, req_addr);
        end
        instr_ready = 1'b1;
        expect_first("rm", 8'h00);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_backpressure();
        test_redirect_drop();
        test_jump_priority();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
